arm_pipelined_decode_execute_reg: RTL and testbench

//  Decode->Execute pipeline register for the pipelined ARM core; direct upstream feeder of the Execute-stage conditional logic.

---
 rtl/arm_pipelined_pkg.sv | 55 +++++
 rtl/arm_pipelined_decode_execute_reg_if.sv | 71 +++++++
 rtl/arm_pipelined_sat_counter.sv | 29 ++
 rtl/arm_pipelined_decode_execute_reg.sv | 130 +++++++++++++
 tb/tb_arm_pipelined_decode_execute_reg.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_pipelined_pkg.sv
// ---------------------------------------------------------------------------
// arm_pipelined_pkg
// Types and constants shared by the Decode->Execute pipeline register.
//   de_ctrl_t      : packed bundle of every decoded control field
//   COND_AL        : ARM "always" condition code
//   DE_CTRL_BUBBLE : control value of an inserted bubble (Cond=AL, rest 0)
//   de_kill_enables: clears every state-changing enable of a control word
// ---------------------------------------------------------------------------
package arm_pipelined_pkg;

  localparam logic [3:0] COND_AL = 4'b1110;

  typedef struct packed {
    logic [3:0] cond;
    logic [1:0] flag_write;   // [1]=NZ write, [0]=CV write
    logic       pc_src;
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       no_write;
    logic       branch;
    logic [1:0] alu_control;
    logic       alu_src;
  } de_ctrl_t;

  localparam de_ctrl_t DE_CTRL_BUBBLE = '{
    cond:        COND_AL,
    flag_write:  2'b00,
    pc_src:      1'b0,
    reg_write:   1'b0,
    mem_write:   1'b0,
    mem_to_reg:  1'b0,
    no_write:    1'b0,
    branch:      1'b0,
    alu_control: 2'b00,
    alu_src:     1'b0
  };

  // An invalid instruction must not change architectural state, so every
  // write/redirect enable is cleared. Cond and ALU selection are kept so the
  // entry still mirrors what Decode presented.
  function automatic de_ctrl_t de_kill_enables(input de_ctrl_t c);
    de_ctrl_t r;
    r            = c;
    r.flag_write = 2'b00;
    r.pc_src     = 1'b0;
    r.reg_write  = 1'b0;
    r.mem_write  = 1'b0;
    r.mem_to_reg = 1'b0;
    r.no_write   = 1'b0;
    r.branch     = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/arm_pipelined_decode_execute_reg_if.sv
// ---------------------------------------------------------------------------
// arm_pipelined_decode_execute_reg_if
// Decode-side inputs and Execute-side outputs of the D->E register.
//   master : the Decode stage (drives *_Decode, observes *_Execute)
//   slave  : the pipeline register (reads *_Decode, drives *_Execute)
// Handshake: there is no valid/ready pair here. i_Valid_Decode qualifies the
// Decode fields every cycle; o_Valid_Execute qualifies the Execute fields.
// Back-pressure comes only from the hazard unit via i_Stall on the register.
// ---------------------------------------------------------------------------
interface arm_pipelined_decode_execute_reg_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
);
  logic                  i_Valid_Decode;
  logic [3:0]            i_Cond_Decode;
  logic [1:0]            i_Flag_Write_Decode;
  logic                  i_PC_Src_Decode;
  logic                  i_Reg_Write_Decode;
  logic                  i_Mem_Write_Decode;
  logic                  i_Mem_To_Reg_Decode;
  logic                  i_No_Write_Decode;
  logic                  i_Branch_Decode;
  logic [1:0]            i_ALU_Control_Decode;
  logic                  i_ALU_Src_Decode;
  logic [DATA_W-1:0]     i_RD1_Decode;
  logic [DATA_W-1:0]     i_RD2_Decode;
  logic [DATA_W-1:0]     i_Ext_Imm_Decode;
  logic [REG_ADDR_W-1:0] i_WA3_Decode;

  logic                  o_Valid_Execute;
  logic [3:0]            o_Cond_Execute;
  logic [1:0]            o_Flag_Write_Execute;
  logic                  o_PC_Src_Execute;
  logic                  o_Reg_Write_Execute;
  logic                  o_Mem_Write_Execute;
  logic                  o_Mem_To_Reg_Execute;
  logic                  o_No_Write_Execute;
  logic                  o_Branch_Execute;
  logic [1:0]            o_ALU_Control_Execute;
  logic                  o_ALU_Src_Execute;
  logic [DATA_W-1:0]     o_RD1_Execute;
  logic [DATA_W-1:0]     o_RD2_Execute;
  logic [DATA_W-1:0]     o_Ext_Imm_Execute;
  logic [REG_ADDR_W-1:0] o_WA3_Execute;

  modport master (
    output i_Valid_Decode, i_Cond_Decode, i_Flag_Write_Decode, i_PC_Src_Decode,
           i_Reg_Write_Decode, i_Mem_Write_Decode, i_Mem_To_Reg_Decode,
           i_No_Write_Decode, i_Branch_Decode, i_ALU_Control_Decode,
           i_ALU_Src_Decode, i_RD1_Decode, i_RD2_Decode, i_Ext_Imm_Decode,
           i_WA3_Decode,
    input  o_Valid_Execute, o_Cond_Execute, o_Flag_Write_Execute,
           o_PC_Src_Execute, o_Reg_Write_Execute, o_Mem_Write_Execute,
           o_Mem_To_Reg_Execute, o_No_Write_Execute, o_Branch_Execute,
           o_ALU_Control_Execute, o_ALU_Src_Execute, o_RD1_Execute,
           o_RD2_Execute, o_Ext_Imm_Execute, o_WA3_Execute
  );

  modport slave (
    input  i_Valid_Decode, i_Cond_Decode, i_Flag_Write_Decode, i_PC_Src_Decode,
           i_Reg_Write_Decode, i_Mem_Write_Decode, i_Mem_To_Reg_Decode,
           i_No_Write_Decode, i_Branch_Decode, i_ALU_Control_Decode,
           i_ALU_Src_Decode, i_RD1_Decode, i_RD2_Decode, i_Ext_Imm_Decode,
           i_WA3_Decode,
    output o_Valid_Execute, o_Cond_Execute, o_Flag_Write_Execute,
           o_PC_Src_Execute, o_Reg_Write_Execute, o_Mem_Write_Execute,
           o_Mem_To_Reg_Execute, o_No_Write_Execute, o_Branch_Execute,
           o_ALU_Control_Execute, o_ALU_Src_Execute, o_RD1_Execute,
           o_RD2_Execute, o_Ext_Imm_Execute, o_WA3_Execute
  );
endinterface

// File: rtl/arm_pipelined_sat_counter.sv
// ---------------------------------------------------------------------------
// arm_pipelined_sat_counter
// Saturating up-counter: +1 on each edge with i_Inc, sticks at all-ones.
//   i_CLK   : clock          i_RESET : async active-high clear
//   i_Inc   : increment      o_Count : registered count (W bits)
// ---------------------------------------------------------------------------
module arm_pipelined_sat_counter #(
  parameter int W = 16
) (
  input  logic         i_CLK,
  input  logic         i_RESET,
  input  logic         i_Inc,
  output logic [W-1:0] o_Count
);
  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_Inc && (count_q != {W{1'b1}})) count_d = count_q + 1'b1;
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) count_q <= '0;
    else         count_q <= count_d;
  end

  assign o_Count = count_q;
endmodule

// File: rtl/arm_pipelined_decode_execute_reg.sv
// ---------------------------------------------------------------------------
// arm_pipelined_decode_execute_reg
// Decode->Execute pipeline register with stall (hold) and flush (bubble).
//   i_CLK, i_RESET   : clock, async active-high reset
//   i_Stall          : hold all contents
//   i_Flush          : write a bubble next edge (wins over i_Stall)
//   de (slave)       : Decode fields in, registered Execute fields out
//   o_Bubble_Count   : saturating count of flush edges
//   o_Stall_Count    : saturating count of stall-only edges
// Build option: ARM_DE_PERF_CNT_EN enables the two counters; otherwise they
// read constant 0 and no counter flops exist.
// Entry state is VALID/BUBBLE, visible directly as o_Valid_Execute.
// ---------------------------------------------------------------------------
module arm_pipelined_decode_execute_reg
  import arm_pipelined_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int PERF_CNT_W = 16
) (
  input  logic                  i_CLK,
  input  logic                  i_RESET,
  input  logic                  i_Stall,
  input  logic                  i_Flush,
  arm_pipelined_decode_execute_reg_if.slave de,
  output logic [PERF_CNT_W-1:0] o_Bubble_Count,
  output logic [PERF_CNT_W-1:0] o_Stall_Count
);
  de_ctrl_t              ctrl_q, ctrl_d, ctrl_in;
  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     rd1_q, rd1_d;
  logic [DATA_W-1:0]     rd2_q, rd2_d;
  logic [DATA_W-1:0]     imm_q, imm_d;
  logic [REG_ADDR_W-1:0] wa3_q, wa3_d;

  always_comb begin
    ctrl_in = '{
      cond:        de.i_Cond_Decode,
      flag_write:  de.i_Flag_Write_Decode,
      pc_src:      de.i_PC_Src_Decode,
      reg_write:   de.i_Reg_Write_Decode,
      mem_write:   de.i_Mem_Write_Decode,
      mem_to_reg:  de.i_Mem_To_Reg_Decode,
      no_write:    de.i_No_Write_Decode,
      branch:      de.i_Branch_Decode,
      alu_control: de.i_ALU_Control_Decode,
      alu_src:     de.i_ALU_Src_Decode
    };
  end

  // Priority: flush > stall > load (reset handled in the flop block).
  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    wa3_d   = wa3_q;
    if (i_Flush) begin
      ctrl_d  = DE_CTRL_BUBBLE;
      valid_d = 1'b0;
      rd1_d   = '0;
      rd2_d   = '0;
      imm_d   = '0;
      wa3_d   = '0;
    end else if (!i_Stall) begin
      ctrl_d  = de.i_Valid_Decode ? ctrl_in : de_kill_enables(ctrl_in);
      valid_d = de.i_Valid_Decode;
      rd1_d   = de.i_RD1_Decode;
      rd2_d   = de.i_RD2_Decode;
      imm_d   = de.i_Ext_Imm_Decode;
      wa3_d   = de.i_WA3_Decode;
    end
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      ctrl_q  <= DE_CTRL_BUBBLE;
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      wa3_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      wa3_q   <= wa3_d;
    end
  end

  assign de.o_Valid_Execute       = valid_q;
  assign de.o_Cond_Execute        = ctrl_q.cond;
  assign de.o_Flag_Write_Execute  = ctrl_q.flag_write;
  assign de.o_PC_Src_Execute      = ctrl_q.pc_src;
  assign de.o_Reg_Write_Execute   = ctrl_q.reg_write;
  assign de.o_Mem_Write_Execute   = ctrl_q.mem_write;
  assign de.o_Mem_To_Reg_Execute  = ctrl_q.mem_to_reg;
  assign de.o_No_Write_Execute    = ctrl_q.no_write;
  assign de.o_Branch_Execute      = ctrl_q.branch;
  assign de.o_ALU_Control_Execute = ctrl_q.alu_control;
  assign de.o_ALU_Src_Execute     = ctrl_q.alu_src;
  assign de.o_RD1_Execute         = rd1_q;
  assign de.o_RD2_Execute         = rd2_q;
  assign de.o_Ext_Imm_Execute     = imm_q;
  assign de.o_WA3_Execute         = wa3_q;

`ifdef ARM_DE_PERF_CNT_EN
  arm_pipelined_sat_counter #(.W(PERF_CNT_W)) u_bubble_cnt (
    .i_CLK   (i_CLK),
    .i_RESET (i_RESET),
    .i_Inc   (i_Flush),
    .o_Count (o_Bubble_Count)
  );

  // A flush overrides a simultaneous stall, so that edge is not a stall.
  arm_pipelined_sat_counter #(.W(PERF_CNT_W)) u_stall_cnt (
    .i_CLK   (i_CLK),
    .i_RESET (i_RESET),
    .i_Inc   (i_Stall & ~i_Flush),
    .o_Count (o_Stall_Count)
  );
`else
  assign o_Bubble_Count = '0;
  assign o_Stall_Count  = '0;
`endif

endmodule

// File: tb/tb_arm_pipelined_decode_execute_reg.sv
// ---------------------------------------------------------------------------
// tb_arm_pipelined_decode_execute_reg
// Self-checking bench for the Decode->Execute pipeline register.
// ---------------------------------------------------------------------------
module tb_arm_pipelined_decode_execute_reg;

  localparam int CW = 4;

  typedef struct packed {
    logic        valid;
    logic [3:0]  cond;
    logic [1:0]  fw;
    logic        pc;
    logic        rw;
    logic        mw;
    logic        m2r;
    logic        nw;
    logic        br;
    logic [1:0]  aluc;
    logic        alus;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [3:0]  wa3;
  } dec_t;

  typedef struct {
    logic stall;
    logic flush;
    dec_t in;
    dec_t exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  logic flush = 1'b0;
  logic [CW-1:0] bub_cnt, stl_cnt;

  always #5 clk = ~clk;

  arm_pipelined_decode_execute_reg_if #(.DATA_W(32), .REG_ADDR_W(4)) de_if ();

  arm_pipelined_decode_execute_reg #(
    .DATA_W(32), .REG_ADDR_W(4), .PERF_CNT_W(CW)
  ) dut (
    .i_CLK          (clk),
    .i_RESET        (rst),
    .i_Stall        (stall),
    .i_Flush        (flush),
    .de             (de_if),
    .o_Bubble_Count (bub_cnt),
    .o_Stall_Count  (stl_cnt)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  dec_t model_out;
  int bub_n = 0;
  int stl_n = 0;
  logic [$bits(dec_t)-1:0] exp_q[$];
  vec_t vecs[6];

  function automatic dec_t mk(logic v, logic [3:0] c, logic [1:0] fw,
                              logic pc, logic rw, logic mw, logic m2r,
                              logic nw, logic br, logic [1:0] ac, logic as,
                              logic [31:0] r1, logic [31:0] r2,
                              logic [31:0] im, logic [3:0] wa);
    dec_t d;
    d = '{valid: v, cond: c, fw: fw, pc: pc, rw: rw, mw: mw, m2r: m2r,
          nw: nw, br: br, aluc: ac, alus: as, rd1: r1, rd2: r2, imm: im,
          wa3: wa};
    return d;
  endfunction

  // Reset value and bubble are the same: invalid, Cond=AL, everything else 0.
  function automatic dec_t empty_entry();
    return mk(0, 4'hE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic dec_t rand_in();
    dec_t d;
    d = dec_t'({$urandom, $urandom, $urandom, $urandom});
    d.valid = ($urandom_range(0, 3) != 0);
    return d;
  endfunction

  // Behaviour of one clock edge, straight from the register's rules.
  function automatic dec_t model_next(dec_t cur, logic st, logic fl, dec_t d);
    dec_t r;
    if (fl) return empty_entry();
    if (st) return cur;
    r = d;
    if (!d.valid) begin
      r.fw = 0; r.pc = 0; r.rw = 0; r.mw = 0; r.m2r = 0; r.nw = 0; r.br = 0;
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] sat(int n);
    int m;
    m = (1 << CW) - 1;
    return (n > m) ? CW'(m) : CW'(n);
  endfunction

  // ---------------- driver / sampler ----------------
  task automatic apply(input dec_t d);
    de_if.i_Valid_Decode       = d.valid;
    de_if.i_Cond_Decode        = d.cond;
    de_if.i_Flag_Write_Decode  = d.fw;
    de_if.i_PC_Src_Decode      = d.pc;
    de_if.i_Reg_Write_Decode   = d.rw;
    de_if.i_Mem_Write_Decode   = d.mw;
    de_if.i_Mem_To_Reg_Decode  = d.m2r;
    de_if.i_No_Write_Decode    = d.nw;
    de_if.i_Branch_Decode      = d.br;
    de_if.i_ALU_Control_Decode = d.aluc;
    de_if.i_ALU_Src_Decode     = d.alus;
    de_if.i_RD1_Decode         = d.rd1;
    de_if.i_RD2_Decode         = d.rd2;
    de_if.i_Ext_Imm_Decode     = d.imm;
    de_if.i_WA3_Decode         = d.wa3;
  endtask

  function automatic dec_t sample();
    return mk(de_if.o_Valid_Execute, de_if.o_Cond_Execute,
              de_if.o_Flag_Write_Execute, de_if.o_PC_Src_Execute,
              de_if.o_Reg_Write_Execute, de_if.o_Mem_Write_Execute,
              de_if.o_Mem_To_Reg_Execute, de_if.o_No_Write_Execute,
              de_if.o_Branch_Execute, de_if.o_ALU_Control_Execute,
              de_if.o_ALU_Src_Execute, de_if.o_RD1_Execute,
              de_if.o_RD2_Execute, de_if.o_Ext_Imm_Execute,
              de_if.o_WA3_Execute);
  endfunction

  task automatic chk(input string name, input dec_t got, input dec_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input logic [CW-1:0] eb,
                         input logic [CW-1:0] es);
    total++;
    if ({bub_cnt, stl_cnt} !== {eb, es}) begin
      bad++;
      $display("FAIL %s bubble=%0d stall=%0d expected bubble=%0d stall=%0d",
               name, bub_cnt, stl_cnt, eb, es);
    end
  endtask

  task automatic chk_model_cnt(input string name);
`ifdef ARM_DE_PERF_CNT_EN
    chk_cnt(name, sat(bub_n), sat(stl_n));
`else
    chk_cnt(name, '0, '0);
`endif
  endtask

  // One clock: drive at negedge, model the edge, compare 1 time unit later.
  task automatic cycle(input logic st, input logic fl, input dec_t d);
    @(negedge clk);
    stall = st;
    flush = fl;
    apply(d);
    @(posedge clk);
    if (!rst) begin
      model_out = model_next(model_out, st, fl, d);
      if (fl) bub_n++;
      else if (st) stl_n++;
    end
    exp_q.push_back(model_out);
    #1;
    chk("model", sample(), dec_t'(exp_q.pop_front()));
    chk_model_cnt("model_cnt");
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    apply(rand_in());
    model_out = empty_entry();
    bub_n = 0;
    stl_n = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("reset_vals", sample(), empty_entry());
      chk_cnt("reset_cnt", '0, '0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    dec_t str_v, add_v, got;
    logic [CW-1:0] exp_b, exp_s;

    apply(empty_entry());
    model_out = empty_entry();

    // Table: each expected value is written out by hand.
    add_v = mk(1, 4'hE, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'd5, 32'd7, 0, 4'd3);
    vecs[0] = '{stall: 0, flush: 0, in: add_v, exp: add_v};
    vecs[1] = '{stall: 0, flush: 0,
                in:  mk(0, 4'h0, 3, 1, 1, 1, 1, 1, 1, 2, 1,
                        32'hAA, 32'hBB, 32'hCC, 4'd9),
                exp: mk(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 2, 1,
                        32'hAA, 32'hBB, 32'hCC, 4'd9)};
    vecs[2] = '{stall: 1, flush: 0,
                in:  mk(1, 4'h1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 2, 3, 4'd4),
                exp: mk(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 2, 1,
                        32'hAA, 32'hBB, 32'hCC, 4'd9)};
    vecs[3] = '{stall: 1, flush: 1,
                in:  mk(1, 4'h1, 3, 1, 1, 1, 1, 1, 1, 3, 1, 9, 9, 9, 4'd9),
                exp: empty_entry()};
    str_v = mk(1, 4'h0, 0, 0, 0, 1, 0, 0, 0, 0, 1,
               32'd100, 32'd200, 32'd8, 4'd1);
    vecs[4] = '{stall: 0, flush: 0, in: str_v, exp: str_v};
    vecs[5] = '{stall: 0, flush: 1, in: str_v, exp: empty_entry()};

    // 1. Reset held for 3 cycles.
    do_reset(3);

    for (int i = 0; i < 6; i++) begin
      cycle(vecs[i].stall, vecs[i].flush, vecs[i].in);
      got = sample();
      chk($sformatf("table[%0d]", i), got, vecs[i].exp);
    end

    // 3. STR then 4 stall cycles with changing Decode inputs.
    cycle(0, 0, str_v);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, rand_in());
      chk($sformatf("stall_hold[%0d]", i), sample(), str_v);
    end

    // Random traffic against the model.
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
            rand_in());
    end

    // 5. Counter saturation and stall counting from a clean reset.
    do_reset(1);
    for (int i = 0; i < 20; i++) cycle(0, 1, rand_in());
`ifdef ARM_DE_PERF_CNT_EN
    exp_b = 4'd15;
    exp_s = 4'd3;
`else
    exp_b = 4'd0;
    exp_s = 4'd0;
`endif
    chk_cnt("bubble_saturate", exp_b, 4'd0);
    for (int i = 0; i < 3; i++) cycle(1, 0, rand_in());
    chk_cnt("stall_count", exp_b, exp_s);

    // 6. Async reset in the middle of a stall cycle.
    cycle(0, 0, add_v);
    chk("pre_async_load", sample(), add_v);
    cycle(1, 0, rand_in());
    chk("pre_async_stall", sample(), add_v);
    #2;
    rst = 1'b1;
    model_out = empty_entry();
    bub_n = 0;
    stl_n = 0;
    #1;
    chk("async_reset_vals", sample(), empty_entry());
    chk_cnt("async_reset_cnt", '0, '0);
    @(negedge clk);
    rst = 1'b0;
    cycle(0, 0, str_v);
    chk("post_reset_load", sample(), str_v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
